// File: rtl/prefetch_fetch_unit.sv
// Instruction-fetch front end: issues reads to a 1-cycle BRAM, buffers words with
// their PCs in a prefetch FIFO and hands them to decode over valid/ready.
module prefetch_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 12,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter int unsigned         FIFO_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                            sysclk,
  input  logic                            rst,
  output logic                            imem_rd_en,
  output logic [PC_WIDTH-1:0]             imem_addr,
  input  logic [INSTR_WIDTH-1:0]          imem_rdata,
  input  logic                            redirect,
  input  logic [PC_WIDTH-1:0]             redirect_pc,
  output logic                            instr_valid,
  input  logic                            instr_ready,
  output logic [INSTR_WIDTH-1:0]          instr,
  output logic [PC_WIDTH-1:0]             instr_pc,
  output logic [PC_WIDTH-1:0]             instr_pc_plus4,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] word;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic                inflight;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  entry_t              mem [FIFO_DEPTH];

  logic [CNT_W:0]      occupancy;
  logic                credit;
  logic                push;
  logic                pop;
  entry_t              head;
  logic                unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // Credit counts in-flight reads so a returning word always finds a free slot.
  assign occupancy  = {1'b0, count} + (CNT_W+1)'(inflight);
  assign credit     = occupancy < (CNT_W+1)'(FIFO_DEPTH);
  assign imem_rd_en = rst & (redirect | credit);
  assign imem_addr  = redirect ? {redirect_pc[PC_WIDTH-1:2], 2'b00} : fetch_pc;

  assign push        = inflight & ~redirect;
  assign instr_valid = (count != '0) & ~redirect;
  assign pop         = instr_valid & instr_ready;

  assign head           = mem[rd_ptr];
  assign instr          = head.word;
  assign instr_pc       = head.pc;
  assign instr_pc_plus4 = head.pc + PC_WIDTH'(4);
  assign fifo_count     = count;

  // Fetch PC, request tracking and FIFO bookkeeping; redirect flushes everything.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= imem_rd_en;
      if (imem_rd_en) begin
        req_pc   <= imem_addr;
        fetch_pc <= imem_addr + PC_WIDTH'(4);
      end
      if (redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset; validity is carried by count.
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= '{word: imem_rdata, pc: req_pc};
  end

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Directed bench for prefetch_fetch_unit with a behavioural 1-cycle BRAM whose
// word at byte address n is 0xA000_0000 | n.
module tb_prefetch_fetch_unit;

  logic        sysclk;
  logic        rst;
  logic        imem_rd_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [11:0] instr_pc;
  logic [11:0] instr_pc_plus4;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  logic inflight_m;

  prefetch_fetch_unit #(
    .PC_WIDTH(12), .INSTR_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(12'h000)
  ) dut (
    .sysclk(sysclk), .rst(rst),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4), .fifo_count(fifo_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (imem_rd_en) imem_rdata <= 32'hA000_0000 | 32'(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A returning word must never find the FIFO full.
  always @(posedge sysclk or negedge rst) begin
    if (!rst) inflight_m <= 1'b0;
    else inflight_m <= imem_rd_en;
  end
  always @(posedge sysclk) begin
    if (rst && inflight_m && !redirect)
      check("no_overflow", {31'd0, fifo_count < 3'd4}, 32'd1);
  end

  task automatic cyc();
    @(posedge sysclk);
    #2;
  endtask

  task automatic head(input string tag, input logic [11:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, {20'd0, instr_pc}, {20'd0, pc});
    check({tag, "_instr"}, instr, 32'hA000_0000 | {20'd0, pc});
    check({tag, "_pc4"}, {20'd0, instr_pc_plus4}, {20'd0, pc + 12'd4});
  endtask

  task automatic cleared(input string tag);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_rd_en"}, {31'd0, imem_rd_en}, 32'd0);
    check({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    imem_rdata = '0;

    // Streaming from reset
    #1 cleared("rst0");
    cyc(); cyc();
    rst = 1'b1;
    #1 check("s_c0_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("s_c0_addr", {20'd0, imem_addr}, 32'h000);
    check("s_c0_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); #1 check("s_c1_addr", {20'd0, imem_addr}, 32'h004);
    check("s_c1_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); #1 head("s_c2", 12'h000);
    check("s_c2_addr", {20'd0, imem_addr}, 32'h008);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1 head("s_stream", 12'(4 * k));
    end

    // Stall: ready low from reset, FIFO fills to depth
    rst = 1'b0; instr_ready = 1'b0;
    #1 cleared("mid_rst");
    cyc(); rst = 1'b1;
    #1 check("st_c0_addr", {20'd0, imem_addr}, 32'h000);
    cyc(); #1 check("st_c1_addr", {20'd0, imem_addr}, 32'h004);
    cyc(); #1 check("st_c2_addr", {20'd0, imem_addr}, 32'h008);
    cyc(); #1 check("st_c3_addr", {20'd0, imem_addr}, 32'h00C);
    check("st_c3_rd_en", {31'd0, imem_rd_en}, 32'd1);
    cyc(); #1 check("st_c4_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("st_c4_count", {29'd0, fifo_count}, 32'd3);
    cyc(); #1 check("st_c5_count", {29'd0, fifo_count}, 32'd4);
    check("st_c5_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cyc(); #1 head("st_c6", 12'h000);
    check("st_c6_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cyc(); instr_ready = 1'b1;
    #1 head("dr_c7", 12'h000);
    check("dr_c7_rd_en", {31'd0, imem_rd_en}, 32'd0);
    cyc(); #1 head("dr_c8", 12'h004);
    check("dr_c8_addr", {20'd0, imem_addr}, 32'h010);
    check("dr_c8_rd_en", {31'd0, imem_rd_en}, 32'd1);
    cyc(); #1 head("dr_c9", 12'h008);
    cyc(); #1 head("dr_c10", 12'h00C);
    cyc(); #1 head("dr_c11", 12'h010);

    // Redirect with 3 buffered entries and one read in flight
    rst = 1'b0; instr_ready = 1'b0;
    #1 cyc(); rst = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    redirect = 1'b1; redirect_pc = 12'h105;
    #1 check("rd_valid", {31'd0, instr_valid}, 32'd0);
    check("rd_addr", {20'd0, imem_addr}, 32'h104);
    check("rd_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("rd_count_pre", {29'd0, fifo_count}, 32'd3);
    cyc(); redirect = 1'b0; instr_ready = 1'b1;
    #1 check("rd_count_flushed", {29'd0, fifo_count}, 32'd0);
    check("rd_valid_next", {31'd0, instr_valid}, 32'd0);
    check("rd_addr_next", {20'd0, imem_addr}, 32'h108);
    cyc(); #1 head("rd_head", 12'h104);
    cyc(); #1 head("rd_head2", 12'h108);

    // Back-to-back redirects
    cyc(); redirect = 1'b1; redirect_pc = 12'h200;
    #1 check("bb1_addr", {20'd0, imem_addr}, 32'h200);
    check("bb1_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); redirect_pc = 12'h300;
    #1 check("bb2_addr", {20'd0, imem_addr}, 32'h300);
    check("bb2_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); redirect = 1'b0;
    #1 check("bb3_valid", {31'd0, instr_valid}, 32'd0);
    check("bb3_count", {29'd0, fifo_count}, 32'd0);
    cyc(); #1 head("bb_head", 12'h300);
    cyc(); #1 head("bb_head2", 12'h304);

    // PC wrap at the top of the address space
    cyc(); redirect = 1'b1; redirect_pc = 12'hFFC;
    #1 check("wr_addr", {20'd0, imem_addr}, 32'hFFC);
    cyc(); redirect = 1'b0;
    #1 check("wr_addr_next", {20'd0, imem_addr}, 32'h000);
    check("wr_valid_next", {31'd0, instr_valid}, 32'd0);
    cyc(); #1 head("wr_head", 12'hFFC);
    check("wr_pc4_zero", {20'd0, instr_pc_plus4}, 32'h000);
    cyc(); #1 head("wr_head2", 12'h000);

    // Reset with two entries buffered and a read in flight
    rst = 1'b0; instr_ready = 1'b0;
    #1 cyc(); rst = 1'b1;
    cyc(); cyc(); cyc();
    #1 check("ar_count_pre", {29'd0, fifo_count}, 32'd2);
    check("ar_rd_en_pre", {31'd0, imem_rd_en}, 32'd1);
    rst = 1'b0;
    #1 cleared("ar_async");
    cyc(); cyc();
    instr_ready = 1'b1; rst = 1'b1;
    #1 check("ar_c0_addr", {20'd0, imem_addr}, 32'h000);
    cyc(); #1 check("ar_c1_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); #1 head("ar_c2", 12'h000);
    cyc(); #1 head("ar_c3", 12'h004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
